// File: rtl/cpu_issue_ctrl.sv
// cpu_issue_ctrl: in-order issue control for the decode slot.
// Tracks per-register result countdowns and a non-pipelined multiplier busy
// counter, detects RAW/WAW/structural hazards, and blocks issue while a
// control-flow instruction is outstanding in execute.
//
// Ports:
//   clk           system clock, all state changes on its rising edge
//   rst_n         synchronous active-low reset
//   valid_instr   decode slot holds an instruction
//   opcode[6:0]   decoded opcode
//   dst/src1/src2 register fields, 5 bits each
//   ex_stall      back end frozen this cycle
//   br_resolved   outstanding control-flow instruction resolves this cycle
//   br_taken      resolved instruction redirects the PC (qualified by br_resolved)
//   issue         decode instruction advances to execute this cycle
//   dec_stall     fetch/decode hold this cycle
//   flush         fetch/decode killed this cycle
//   illegal_instr one-cycle pulse for an undefined opcode
// Outputs are combinational functions of the inputs and the current state.
module cpu_issue_ctrl #(
    parameter int unsigned LD_LAT  = 3,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_instr,
    input  logic [6:0] opcode,
    input  logic [4:0] dst,
    input  logic [4:0] src1,
    input  logic [4:0] src2,
    input  logic       ex_stall,
    input  logic       br_resolved,
    input  logic       br_taken,
    output logic       issue,
    output logic       dec_stall,
    output logic       flush,
    output logic       illegal_instr
);

    localparam int unsigned CW   = 3;
    localparam int unsigned NREG = 32;

    localparam logic [CW-1:0] LD_M1  = CW'(LD_LAT - 1);
    localparam logic [CW-1:0] MUL_M1 = CW'(MUL_LAT - 1);

    localparam logic [6:0] OP_ADD      = 7'h00;
    localparam logic [6:0] OP_SUB      = 7'h01;
    localparam logic [6:0] OP_MUL      = 7'h02;
    localparam logic [6:0] OP_LDB      = 7'h10;
    localparam logic [6:0] OP_LDW      = 7'h11;
    localparam logic [6:0] OP_STB      = 7'h12;
    localparam logic [6:0] OP_STW      = 7'h13;
    localparam logic [6:0] OP_MOV      = 7'h14;
    localparam logic [6:0] OP_BEQ      = 7'h30;
    localparam logic [6:0] OP_JUMP     = 7'h31;
    localparam logic [6:0] OP_TLBWRITE = 7'h32;
    localparam logic [6:0] OP_IRET     = 7'h33;

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_BR = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt [NREG];
    logic [CW-1:0] mul_cnt;

    logic          legal;
    logic          rd_s1;
    logic          rd_s2;
    logic          rd_dst;
    logic          wr;
    logic          is_mul;
    logic          is_ctl;
    logic [CW-1:0] lat_m1;

    logic          raw_haz;
    logic          waw_haz;
    logic          mul_haz;
    logic          hazard;

    // Opcode decode: source usage, destination write, latency class.
    always_comb begin : decode
        legal  = 1'b1;
        rd_s1  = 1'b0;
        rd_s2  = 1'b0;
        rd_dst = 1'b0;
        wr     = 1'b0;
        is_mul = 1'b0;
        is_ctl = 1'b0;
        lat_m1 = '0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                rd_s1 = 1'b1;
                rd_s2 = 1'b1;
                wr    = 1'b1;
            end
            OP_MUL: begin
                rd_s1  = 1'b1;
                rd_s2  = 1'b1;
                wr     = 1'b1;
                is_mul = 1'b1;
                lat_m1 = MUL_M1;
            end
            OP_LDB, OP_LDW: begin
                rd_s1  = 1'b1;
                wr     = 1'b1;
                lat_m1 = LD_M1;
            end
            OP_STB, OP_STW: begin
                rd_s1  = 1'b1;
                rd_dst = 1'b1;
            end
            OP_MOV: begin
                rd_s1 = 1'b1;
                wr    = 1'b1;
            end
            OP_BEQ: begin
                rd_s1  = 1'b1;
                rd_s2  = 1'b1;
                is_ctl = 1'b1;
            end
            OP_JUMP: begin
                rd_s1  = 1'b1;
                is_ctl = 1'b1;
            end
            OP_TLBWRITE: begin
                rd_s1 = 1'b1;
                rd_s2 = 1'b1;
            end
            OP_IRET: begin
                is_ctl = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Hazards; a WAW only matters if the older write would land at or after ours.
    always_comb begin : hazards
        raw_haz = (rd_s1  && (cnt[src1] != '0)) ||
                  (rd_s2  && (cnt[src2] != '0)) ||
                  (rd_dst && (cnt[dst]  != '0));
        waw_haz = wr && (cnt[dst] != '0) && (cnt[dst] >= lat_m1);
        mul_haz = is_mul && (mul_cnt != '0);
        hazard  = raw_haz || waw_haz || mul_haz;
    end

    // State register.
    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs; everything is forced low while reset is held.
    always_comb begin : fsm_comb
        state_nxt     = state;
        issue         = 1'b0;
        dec_stall     = 1'b0;
        flush         = 1'b0;
        illegal_instr = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (valid_instr && !ex_stall && !legal) begin
                        illegal_instr = 1'b1;
                    end else if (valid_instr && !ex_stall && !hazard) begin
                        issue = 1'b1;
                        if (is_ctl) begin
                            state_nxt = WAIT_BR;
                        end
                    end
                    dec_stall = valid_instr && !issue;
                end
                WAIT_BR: begin
                    dec_stall = valid_instr;
                    if (br_resolved && !ex_stall) begin
                        flush     = br_taken;
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    // Register countdowns: an issue load wins over the decrement.
    always_ff @(posedge clk) begin : reg_counters
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (issue && wr && (dst == 5'(i))) begin
                    cnt[i] <= lat_m1;
                end else if (!ex_stall && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    // Multiplier busy countdown.
    always_ff @(posedge clk) begin : mul_counter
        if (!rst_n) begin
            mul_cnt <= '0;
        end else if (issue && is_mul) begin
            mul_cnt <= MUL_M1;
        end else if (!ex_stall && (mul_cnt != '0)) begin
            mul_cnt <= mul_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Testbench for cpu_issue_ctrl: directed scenarios plus random stimulus,
// checked by a timestamp-based reference model through a scoreboard queue.
module tb_cpu_issue_ctrl;

    localparam int unsigned LD_LAT  = 3;
    localparam int unsigned MUL_LAT = 5;

    localparam logic [6:0] OP_ADD      = 7'h00;
    localparam logic [6:0] OP_SUB      = 7'h01;
    localparam logic [6:0] OP_MUL      = 7'h02;
    localparam logic [6:0] OP_LDB      = 7'h10;
    localparam logic [6:0] OP_LDW      = 7'h11;
    localparam logic [6:0] OP_STB      = 7'h12;
    localparam logic [6:0] OP_STW      = 7'h13;
    localparam logic [6:0] OP_MOV      = 7'h14;
    localparam logic [6:0] OP_BEQ      = 7'h30;
    localparam logic [6:0] OP_JUMP     = 7'h31;
    localparam logic [6:0] OP_TLBWRITE = 7'h32;
    localparam logic [6:0] OP_IRET     = 7'h33;
    localparam logic [6:0] OP_BAD      = 7'h7F;

    typedef struct packed {
        logic issue;
        logic dec_stall;
        logic flush;
        logic illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_instr;
    logic [6:0] opcode;
    logic [4:0] dst;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       ex_stall;
    logic       br_resolved;
    logic       br_taken;
    logic       issue;
    logic       dec_stall;
    logic       flush;
    logic       illegal_instr;

    int total = 0;
    int bad   = 0;

    exp_t expq [$];
    exp_t last_e;

    // Reference model: unstalled-cycle timestamps instead of countdowns.
    int ucnt;
    int ready [32];
    int mul_ready;
    bit m_wait;

    cpu_issue_ctrl #(.LD_LAT(LD_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_instr  (valid_instr),
        .opcode       (opcode),
        .dst          (dst),
        .src1         (src1),
        .src2         (src2),
        .ex_stall     (ex_stall),
        .br_resolved  (br_resolved),
        .br_taken     (br_taken),
        .issue        (issue),
        .dec_stall    (dec_stall),
        .flush        (flush),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic bit m_legal(input logic [6:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW,
                          OP_MOV, OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET};
    endfunction

    function automatic bit m_writes(input logic [6:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MOV, OP_LDB, OP_LDW, OP_MUL};
    endfunction

    function automatic bit m_rd_s1(input logic [6:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_BEQ, OP_TLBWRITE, OP_LDB,
                          OP_LDW, OP_MOV, OP_JUMP, OP_STB, OP_STW};
    endfunction

    function automatic bit m_rd_s2(input logic [6:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_BEQ, OP_TLBWRITE};
    endfunction

    function automatic bit m_rd_dst(input logic [6:0] op);
        return op inside {OP_STB, OP_STW};
    endfunction

    function automatic bit m_ctl(input logic [6:0] op);
        return op inside {OP_BEQ, OP_JUMP, OP_IRET};
    endfunction

    function automatic int m_lat(input logic [6:0] op);
        if (op == OP_MUL) return MUL_LAT;
        if (op == OP_LDB || op == OP_LDW) return LD_LAT;
        return 1;
    endfunction

    function automatic int m_rem(input logic [4:0] r);
        return (ready[r] > ucnt) ? ready[r] - ucnt : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) ready[i] = 0;
        mul_ready = 0;
        ucnt      = 0;
        m_wait    = 1'b0;
    endtask

    // Drive one cycle of inputs, predict outputs, push the prediction.
    task automatic step(input bit r, input bit v, input logic [6:0] op,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input bit st, input bit res, input bit tk);
        exp_t e;
        bit   haz;
        @(posedge clk);
        #1;
        rst_n       = r;
        valid_instr = v;
        opcode      = op;
        dst         = d;
        src1        = s1;
        src2        = s2;
        ex_stall    = st;
        br_resolved = res;
        br_taken    = tk;
        e = '0;
        if (!r) begin
            m_reset();
        end else begin
            if (m_wait) begin
                e.dec_stall = v;
                if (res && !st) begin
                    e.flush = tk;
                    m_wait  = 1'b0;
                end
            end else if (v && !st && !m_legal(op)) begin
                e.illegal   = 1'b1;
                e.dec_stall = 1'b1;
            end else begin
                haz = (m_rd_s1(op)  && m_rem(s1) > 0) ||
                      (m_rd_s2(op)  && m_rem(s2) > 0) ||
                      (m_rd_dst(op) && m_rem(d)  > 0) ||
                      (m_writes(op) && m_rem(d) > 0 && m_rem(d) >= m_lat(op) - 1) ||
                      (op == OP_MUL && mul_ready > ucnt);
                e.issue     = v && !st && !haz;
                e.dec_stall = v && !e.issue;
                if (e.issue) begin
                    if (m_writes(op)) ready[d] = ucnt + m_lat(op);
                    if (op == OP_MUL) mul_ready = ucnt + MUL_LAT;
                    if (m_ctl(op)) m_wait = 1'b1;
                end
            end
            if (!st) ucnt++;
        end
        last_e = e;
        expq.push_back(e);
    endtask

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic do_reset();
        step(0, 0, OP_ADD, 0, 0, 0, 0, 0, 0);
        step(0, 0, OP_ADD, 0, 0, 0, 0, 0, 0);
    endtask

    // Present an instruction until the DUT issues it; returns stall cycles or -1.
    task automatic run_instr(input logic [6:0] op, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2, output int stalls);
        int n    = 0;
        bit done = 1'b0;
        stalls = -1;
        while (!done && n < 20) begin
            step(1, 1, op, d, s1, s2, 0, 0, 0);
            @(negedge clk);
            if (issue) done = 1'b1;
            else n++;
        end
        if (done) stalls = n;
    endtask

    // Scoreboard monitor: compares every predicted cycle at the falling edge.
    initial begin : monitor
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e   = expq.pop_front();
                act = {issue, dec_stall, flush, illegal_instr};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL outputs{issue,dec_stall,flush,illegal} at %0t: got %b expected %b",
                             $time, act, e);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [6:0] ops [14] = '{OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW,
                             OP_MOV, OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET, OP_BAD, 7'h05};

    initial begin : stimulus
        int         s;
        bit         have;
        logic [6:0] c_op;
        logic [4:0] c_d;
        logic [4:0] c_s1;
        logic [4:0] c_s2;
        bit         v;
        bit         st;
        bit         res;
        bit         r;

        rst_n = 0; valid_instr = 0; opcode = '0; dst = '0; src1 = '0; src2 = '0;
        ex_stall = 0; br_resolved = 0; br_taken = 0;
        m_reset();

        // Load-use: two stall cycles then issue.
        do_reset();
        run_instr(OP_LDW, 3, 1, 0, s);  check("ldw_issue", s, 0);
        run_instr(OP_ADD, 4, 3, 1, s);  check("load_use_stall", s, 2);

        // Back-to-back multiplies.
        do_reset();
        run_instr(OP_MUL, 5, 1, 2, s);  check("mul1_issue", s, 0);
        run_instr(OP_MUL, 6, 1, 2, s);  check("mul_struct_stall", s, 4);

        // Independent ADD slips between multiplies.
        do_reset();
        run_instr(OP_MUL, 5, 1, 2, s);  check("mul1b_issue", s, 0);
        run_instr(OP_ADD, 7, 1, 2, s);  check("add_between_muls", s, 0);
        run_instr(OP_MUL, 6, 1, 2, s);  check("mul_after_add_stall", s, 3);

        // WAW behind a multiply.
        do_reset();
        run_instr(OP_MUL, 8, 1, 2, s);  check("mul_r8_issue", s, 0);
        run_instr(OP_ADD, 8, 1, 2, s);  check("waw_stall", s, 4);

        // Taken branch resolving two cycles after issue.
        do_reset();
        run_instr(OP_BEQ, 0, 1, 2, s);  check("beq_issue", s, 0);
        step(1, 1, OP_ADD, 9, 1, 2, 0, 0, 0);
        @(negedge clk);
        check("wait_br_issue", int'(issue), 0);
        check("wait_br_dec_stall", int'(dec_stall), 1);
        step(1, 1, OP_ADD, 9, 1, 2, 0, 1, 1);
        @(negedge clk);
        check("resolve_flush", int'(flush), 1);
        check("resolve_issue", int'(issue), 0);
        run_instr(OP_ADD, 9, 1, 2, s);  check("post_branch_issue", s, 0);

        // Back-end freeze holds the load countdown.
        do_reset();
        run_instr(OP_LDW, 3, 1, 0, s);  check("ldw2_issue", s, 0);
        for (int i = 0; i < 3; i++) step(1, 1, OP_ADD, 4, 3, 1, 1, 0, 0);
        run_instr(OP_ADD, 4, 3, 1, s);  check("frozen_load_use_stall", s, 2);

        // Undefined opcode.
        do_reset();
        step(1, 1, OP_BAD, 1, 2, 3, 0, 0, 0);
        @(negedge clk);
        check("illegal_pulse", int'(illegal_instr), 1);
        check("illegal_no_issue", int'(issue), 0);
        step(1, 0, OP_ADD, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("illegal_drops", int'(illegal_instr), 0);

        // Reset while waiting on a branch: no flush, back to RUN.
        do_reset();
        run_instr(OP_JUMP, 0, 1, 0, s); check("jump_issue", s, 0);
        step(1, 1, OP_ADD, 2, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("jump_wait_issue", int'(issue), 0);
        step(0, 1, OP_ADD, 2, 1, 1, 0, 1, 1);
        @(negedge clk);
        check("reset_no_flush", int'(flush), 0);
        step(1, 0, OP_ADD, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("post_reset_outputs", int'({issue, dec_stall, flush, illegal_instr}), 0);
        run_instr(OP_ADD, 2, 1, 1, s);  check("post_reset_run", s, 0);

        // Random traffic; instructions are held until issued or rejected.
        do_reset();
        have = 1'b0;
        c_op = OP_ADD; c_d = '0; c_s1 = '0; c_s2 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!have) begin
                c_op = ops[$urandom_range(0, 13)];
                c_d  = 5'($urandom_range(0, 7));
                c_s1 = 5'($urandom_range(0, 7));
                c_s2 = 5'($urandom_range(0, 7));
                have = 1'b1;
            end
            v   = ($urandom_range(0, 9) != 0);
            st  = ($urandom_range(0, 4) == 0);
            res = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            r   = ($urandom_range(0, 199) != 0);
            step(r, v, c_op, c_d, c_s1, c_s2, st, res, 1'($urandom_range(0, 1)));
            if (last_e.issue || last_e.illegal) have = 1'b0;
        end

        step(1, 0, OP_ADD, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d predictions left, expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_issue_ctrl.md
CPU_ISSUE_CTRL -- requirements
Module: cpu_issue_ctrl

Interface
REQ-001 SHALL have parameter LD_LAT, default 3, meaning load result latency in cycles from issue to writeback.
REQ-002 SHALL have parameter MUL_LAT, default 5, meaning multiply latency in cycles; the multiplier is non-pipelined.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port valid_instr, input, 1, meaning the decode slot holds an instruction.
REQ-006 SHALL have port opcode, input, 7, meaning the decoded opcode (ADD=0x00 SUB=0x01 MUL=0x02 LDB=0x10 LDW=0x11 STB=0x12 STW=0x13 MOV=0x14 BEQ=0x30 JUMP=0x31 TLBWRITE=0x32 IRET=0x33).
REQ-007 SHALL have ports dst, src1 and src2, input, 5 each, meaning instruction bits [24:20], [19:15] and [14:10].
REQ-008 SHALL have port ex_stall, input, 1, meaning the back end is frozen this cycle.
REQ-009 SHALL have port br_resolved, input, 1, meaning execute resolves the outstanding control-flow instruction this cycle.
REQ-010 SHALL have port br_taken, input, 1, meaning the resolved control-flow instruction redirects the PC; qualified by br_resolved.
REQ-011 SHALL have port issue, output, 1, meaning the decode instruction advances to execute this cycle.
REQ-012 SHALL have port dec_stall, output, 1, meaning fetch/decode hold this cycle.
REQ-013 SHALL have port flush, output, 1, meaning fetch/decode are killed this cycle.
REQ-014 SHALL have port illegal_instr, output, 1, meaning a one-cycle pulse for an undefined opcode.

Function
REQ-015 SHALL treat sources as follows: ADD/SUB/MUL/BEQ/TLBWRITE read src1 and src2; LDB/LDW/MOV/JUMP read src1; STB/STW read src1 and dst; IRET reads none.
REQ-016 SHALL treat ADD/SUB/MOV/LDB/LDW/MUL as writers of dst; no register is special-cased.
REQ-017 SHALL keep a 3-bit countdown per register (32 entries); on issue of a writer, cnt[dst] is loaded with latency-1, where latency is 1 for ALU/MOV, LD_LAT for loads and MUL_LAT for MUL.
REQ-018 SHALL decrement every nonzero counter by 1 per cycle while ex_stall=0 and hold all counters while ex_stall=1.
REQ-019 SHALL raise a RAW hazard when any read source has cnt!=0.
REQ-020 SHALL raise a WAW hazard when a writer's cnt[dst] is greater than or equal to its own latency-1, with cnt[dst]!=0.
REQ-021 SHALL keep a MUL busy counter loaded with MUL_LAT-1 on MUL issue; a MUL while the counter is nonzero is a structural hazard.
REQ-022 SHALL use FSM states RUN and WAIT_BR.
REQ-023 In RUN, SHALL assert issue combinationally when valid_instr=1, ex_stall=0, the opcode is legal and no hazard exists; otherwise dec_stall=valid_instr.
REQ-024 On issue of BEQ, JUMP or IRET, SHALL transition RUN->WAIT_BR.
REQ-025 In WAIT_BR, SHALL hold issue=0 and dec_stall=valid_instr.
REQ-026 In WAIT_BR, when br_resolved=1 and ex_stall=0, SHALL return to RUN next cycle with flush=br_taken in that cycle; no issue occurs in the resolve cycle.
REQ-027 SHALL ignore br_resolved while in RUN or while ex_stall=1.
REQ-028 For an undefined opcode in RUN with valid_instr=1 and ex_stall=0, SHALL pulse illegal_instr for 1 cycle, leave issue=0, and update no state.
REQ-029 SHALL update counters with the same-cycle issue load taking priority over decrement for that register.
REQ-030 SHALL keep issue, flush and illegal_instr mutually exclusive.

Reset
REQ-031 While rst_n=0 at a clock edge, SHALL clear all register counters and the MUL counter, set state to RUN, and drive issue=dec_stall=flush=illegal_instr=0.
REQ-032 SHALL allow reset mid-operation, including in WAIT_BR or with counters nonzero, to abandon all pending state without a flush pulse.

Verification
REQ-033 Bench SHALL cover: LDW r3 then ADD r4,r3,r1 back-to-back -> ADD stalls 2 cycles (dec_stall=1) and issues on the 3rd cycle.
REQ-034 Bench SHALL cover: MUL r5 then MUL r6 independent -> second MUL stalls 4 cycles; ADD r7,r1,r2 in between issues with no stall.
REQ-035 Bench SHALL cover: BEQ issued, br_resolved=1, br_taken=1 two cycles later -> issue=0 for both cycles, flush=1 in the resolve cycle, next instruction issues one cycle later.
REQ-036 Bench SHALL cover: MUL r8 then ADD r8 -> ADD (WAW) stalls until cnt[8]=0, i.e. 4 cycles.
REQ-037 Bench SHALL cover: ex_stall=1 for 3 cycles after LDW r3 -> counters frozen; the dependent instruction issues exactly 2 unstalled cycles later.
REQ-038 Bench SHALL cover: opcode 0x7F with valid_instr=1 -> illegal_instr=1 for one cycle and issue=0; rst_n=0 in WAIT_BR -> RUN with all outputs 0 next cycle.
